// File: rtl/acoustics_pkg.sv
// acoustics_pkg: shared defaults and FSM encoding for the FFT frame scheduler.
package acoustics_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int DATA_W_DEF      = 10;
  localparam int FRAME_LEN_DEF   = 64;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_FFT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches upward from
// last_grant+1 (mod NUM_CH) and returns the first pending channel.
module rr_arbiter
  import acoustics_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_pending,
  input  logic [CH_W-1:0]   i_last,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_valid
);

  // Walk offsets from farthest to nearest so the nearest pending channel is written last and wins.
  always_comb begin
    int              w_sum;
    logic [CH_W-1:0] w_idx;
    w_sum   = 0;
    w_idx   = '0;
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_sum = int'(i_last) + k;
      if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
      w_idx = CH_W'(w_sum);
      if (i_pending[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: shares one FFT engine among NUM_CH ring buffers.
// Latches frame requests, grants one channel at a time round-robin, streams
// FRAME_LEN samples into the FFT and waits for fft_done before moving on.
// Build macro FRAME_TIMEOUT_EN: abandon the frame if fft_done does not arrive
// within TIMEOUT_CYC cycles of WAIT_FFT and raise a sticky timeout_err.
module fft_frame_scheduler
  import acoustics_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_CH-1:0]        i_ch_req,
  input  logic [NUM_CH-1:0]        i_ch_enable,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  output logic [NUM_CH-1:0]        o_ch_send_frame,
  output logic [DATA_W-1:0]        o_fft_data,
  output logic                     o_fft_data_valid,
  input  logic                     i_fft_done,
  output logic                     o_busy,
  output logic [CH_W-1:0]          o_active_ch,
  output logic [15:0]              o_frame_count,
  output logic                     o_timeout_err
);

  if (NUM_CH < 2 || FRAME_LEN < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("fft_frame_scheduler: unsupported parameter set");
  end

  sched_state_e                  r_state;
  logic [NUM_CH-1:0]             r_pending;
  logic [NUM_CH-1:0]             r_send;
  logic [CH_W-1:0]               r_active;
  logic [CH_W-1:0]               r_last;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_busy;
  logic [15:0]                   r_count;
  logic [DATA_W-1:0]             r_data;
  logic                          r_valid;

  logic [NUM_CH-1:0][DATA_W-1:0] w_ch_data;
  logic [NUM_CH-1:0]             w_act_mask;
  logic [NUM_CH-1:0]             w_set;
  logic [NUM_CH-1:0]             w_dis_clr;
  logic [NUM_CH-1:0]             w_fin_clr;
  logic [CH_W-1:0]               w_grant;
  logic                          w_grant_vld;
  logic                          w_done;
  logic                          w_tout;
  logic                          w_finish;

  assign w_ch_data  = i_ch_data;
  assign w_act_mask = NUM_CH'(1) << r_active;
  assign w_done     = (r_state == S_WAIT_FFT) & i_fft_done;
  assign w_finish   = w_done | w_tout;
  assign w_set      = i_ch_req & i_ch_enable;
  // The channel currently holding the engine is immune to disable; it finishes its frame.
  assign w_dis_clr  = ~i_ch_enable & ~(r_busy ? w_act_mask : '0);
  assign w_fin_clr  = w_finish ? w_act_mask : '0;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_valid   (w_grant_vld)
  );

  // Pending requests: a new request outranks both disable and completion clears.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pending <= '0;
    else         r_pending <= w_set | (r_pending & ~w_dis_clr & ~w_fin_clr);
  end

  // Scheduler FSM with registered send_frame / busy / active / frame count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_send   <= '0;
      r_active <= '0;
      r_last   <= CH_W'(NUM_CH - 1);
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_active <= w_grant;
            r_send   <= NUM_CH'(1) << w_grant;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
            r_send  <= '0;
            r_state <= S_WAIT_FFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_FFT: begin
          if (w_finish) begin
            if (w_done) r_count <= r_count + 16'd1;
            r_last  <= r_active;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_send  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ring buffers answer one cycle after send_frame, so the FFT beat trails it by one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= |r_send;
      r_data  <= (|r_send) ? w_ch_data[r_active] : '0;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_wcnt;
  logic            r_tout_err;

  assign w_tout = (r_state == S_WAIT_FFT) & ~i_fft_done & (r_wcnt == TO_W'(TIMEOUT_CYC - 1));

  // Cycles spent in WAIT_FFT for the current frame.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != S_WAIT_FFT) r_wcnt <= '0;
    else                                  r_wcnt <= r_wcnt + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_tout_err <= 1'b0;
    else if (w_tout) r_tout_err <= 1'b1;
  end

  assign o_timeout_err = r_tout_err;
`else
  assign w_tout        = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_ch_send_frame  = r_send;
  assign o_fft_data       = r_data;
  assign o_fft_data_valid = r_valid;
  assign o_busy           = r_busy;
  assign o_active_ch      = r_active;
  assign o_frame_count    = r_count;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler: a frame-level reference model
// predicts grants, beats and counters; a negedge monitor compares.
module tb_fft_frame_scheduler;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 10;
  localparam int FRAME_LEN = 64;
`ifdef FRAME_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;
`else
  localparam int TIMEOUT_CYC = 4096;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        req = '0;
  logic [NUM_CH-1:0]        en = '1;
  logic [NUM_CH*DATA_W-1:0] data = '0;
  logic                     done = 1'b0;
  logic [NUM_CH-1:0]        o_send;
  logic [DATA_W-1:0]        o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic [1:0]               o_act;
  logic [15:0]              o_count;
  logic                     o_terr;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN),
                        .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(clk), .i_reset(reset), .i_ch_req(req), .i_ch_enable(en), .i_ch_data(data),
    .o_ch_send_frame(o_send), .o_fft_data(o_data), .o_fft_data_valid(o_valid),
    .i_fft_done(done), .o_busy(o_busy), .o_active_ch(o_act), .o_frame_count(o_count),
    .o_timeout_err(o_terr)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    errors++;
    $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // ---------------- reference model (phase: 0 idle, 1 streaming, 2 awaiting FFT) ----------------
  bit [NUM_CH-1:0]   m_pend = '0;
  int                m_last = NUM_CH - 1;
  int                m_phase = 0;
  int                m_beat = 0;
  int                m_act = 0;
  int                m_count = 0;
  int                m_wait = 0;
  bit                m_terr = 1'b0;
  bit                exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  always @(posedge clk) begin : model
    bit              fin;
    bit              busy_old;
    bit              found;
    int              a_old;
    bit [NUM_CH-1:0] old_p;
    if (reset) begin
      m_pend = '0; m_last = NUM_CH - 1; m_phase = 0; m_beat = 0; m_act = 0;
      m_count = 0; m_wait = 0; m_terr = 1'b0; exp_valid = 1'b0;
      exp_q.delete();
    end else begin
      busy_old = (m_phase != 0);
      a_old    = m_act;
      old_p    = m_pend;
      fin      = 1'b0;
      if (m_phase == 2) begin
        if (done) fin = 1'b1;
`ifdef FRAME_TIMEOUT_EN
        else if (m_wait + 1 == TIMEOUT_CYC) begin fin = 1'b1; m_terr = 1'b1; end
`endif
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en[i] && !(busy_old && i == a_old)) m_pend[i] = 1'b0;
        if (fin && i == a_old) m_pend[i] = 1'b0;
        if (req[i] && en[i]) m_pend[i] = 1'b1;
      end
      exp_valid = (m_phase == 1);
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= NUM_CH; k++)
            if (!found && old_p[(m_last + k) % NUM_CH]) begin
              found = 1'b1;
              m_act = (m_last + k) % NUM_CH;
            end
          if (found) begin m_phase = 1; m_beat = 0; end
        end
        1: begin
          exp_q.push_back(data[m_act*DATA_W +: DATA_W]);
          m_beat++;
          if (m_beat == FRAME_LEN) begin m_phase = 2; m_wait = 0; end
        end
        default: begin
          if (fin) begin
            if (done) m_count = (m_count + 1) % 65536;
            m_last  = m_act;
            m_phase = 0;
          end else m_wait++;
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  int                grants[$];
  int                beats = 0;
  logic [NUM_CH-1:0] prev_send = '0;

  always @(negedge clk) begin : monitor
    logic [NUM_CH-1:0] es;
    logic [DATA_W-1:0] ed;
    es = (m_phase == 1) ? (NUM_CH'(1) << m_act) : '0;
    chk("send_frame", 32'(o_send), 32'(es));
    chk("busy", 32'(o_busy), 32'(m_phase != 0));
    chk("active_ch", 32'(o_act), 32'(m_act));
    chk("frame_count", 32'(o_count), 32'(m_count));
    chk("timeout_err", 32'(o_terr), 32'(m_terr));
    chk("data_valid", 32'(o_valid), 32'(exp_valid));
    if (o_valid === 1'b1) begin
      beats++;
      if (exp_q.size() == 0) fail("data_extra", 32'(o_data), 0);
      else begin
        ed = exp_q.pop_front();
        chk("fft_data", 32'(o_data), 32'(ed));
      end
    end else if (exp_valid && exp_q.size() != 0) begin
      ed = exp_q.pop_front();
    end
    if (o_send != '0 && prev_send == '0) grants.push_back(int'(o_act));
    prev_send = o_send;
  end

  // Fresh sample on every ring-buffer output each cycle.
  always @(negedge clk) begin : data_drv
    for (int i = 0; i < NUM_CH; i++) data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; en = '1; done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_req(input logic [NUM_CH-1:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic wait_phase(input int ph, input int ch, input int lim);
    int n;
    n = 0;
    while (!(m_phase == ph && (ch < 0 || m_act == ch)) && n < lim) begin
      tick();
      n++;
    end
    if (!(m_phase == ph && (ch < 0 || m_act == ch))) fail("wait_bound", 32'(m_phase), 32'(ph));
  endtask

  task automatic give_done(input int dly);
    wait_phase(2, -1, 300);
    repeat (dly) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic chk_grants(input string nm, input int g0, input int exp[$]);
    chk({nm, "_n"}, 32'(grants.size() - g0), 32'(exp.size()));
    if (grants.size() - g0 == exp.size())
      foreach (exp[k]) chk(nm, 32'(grants[g0 + k]), 32'(exp[k]));
  endtask

  initial begin : stim
    int g0;
    int b0;
    int n;

    // Reset state
    do_reset();
    chk("rst_send", 32'(o_send), 0);
    chk("rst_count", 32'(o_count), 0);

    // 1: single request on channel 2
    b0 = beats;
    pulse_req(4'b0100);
    chk("s1_send_early", 32'(o_send), 0);
    tick();
    chk("s1_send_lat", 32'(o_send), 32'h4);
    give_done(5);
    chk("s1_beats", 32'(beats - b0), FRAME_LEN);
    chk("s1_count", 32'(o_count), 1);
    chk("s1_busy", 32'(o_busy), 0);

    // 2: all four pending, then re-request channel 0
    do_reset();
    g0 = grants.size();
    pulse_req(4'b1111);
    repeat (4) give_done(10);
    chk("s2_count", 32'(o_count), 4);
    pulse_req(4'b0001);
    give_done(10);
    chk_grants("s2_grant", g0, '{0, 1, 2, 3, 0});

    // 3: channel 1 disabled while pending, then disabled during its own frame
    do_reset();
    g0 = grants.size();
    pulse_req(4'b0011);
    wait_phase(1, 0, 20);
    en[1] = 1'b0;
    give_done(3);
    repeat (5) tick();
    chk("s3_idle", 32'(o_busy), 0);
    chk_grants("s3_grant", g0, '{0});
    en = '1;
    pulse_req(4'b0010);
    wait_phase(1, 1, 20);
    b0 = beats;
    repeat (5) tick();
    en[1] = 1'b0;
    give_done(2);
    en = '1;
    chk("s3_beats", 32'(beats - b0), FRAME_LEN);

    // 4: re-request of channel 3 in the same cycle as its fft_done
    do_reset();
    g0 = grants.size();
    pulse_req(4'b1000);
    wait_phase(1, 3, 20);
    pulse_req(4'b0001);
    wait_phase(2, 3, 200);
    repeat (3) tick();
    req = 4'b1000; done = 1'b1;
    tick();
    req = '0; done = 1'b0;
    give_done(4);
    give_done(4);
    chk_grants("s4_grant", g0, '{3, 0, 3});

    // 5: reset in the middle of a frame
    do_reset();
    pulse_req(4'b0001);
    wait_phase(1, 0, 20);
    n = 0;
    while (m_beat < 30 && n < 100) begin tick(); n++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_send", 32'(o_send), 0);
    chk("s5_busy", 32'(o_busy), 0);
    chk("s5_valid", 32'(o_valid), 0);
    b0 = beats;
    pulse_req(4'b0100);
    give_done(2);
    chk("s5_beats", 32'(beats - b0), FRAME_LEN);

    // 6: missing fft_done
    do_reset();
    pulse_req(4'b0110);
`ifdef FRAME_TIMEOUT_EN
    wait_phase(2, 1, 200);
    repeat (TIMEOUT_CYC + 1) tick();
    chk("s6_terr", 32'(o_terr), 1);
    wait_phase(1, 2, 50);
    chk("s6_next_ch", 32'(o_act), 2);
    chk("s6_count0", 32'(o_count), 0);
    give_done(3);
    chk("s6_count1", 32'(o_count), 1);
`else
    wait_phase(2, 1, 200);
    repeat (10000) tick();
    chk("s6_still_busy", 32'(o_busy), 1);
    chk("s6_no_send", 32'(o_send), 0);
    chk("s6_terr", 32'(o_terr), 0);
    give_done(0);
    give_done(3);
`endif

    // Random traffic: requests, enable toggles, stray fft_done, rare resets
    do_reset();
    repeat (3000) begin
      req = '0;
      for (int i = 0; i < NUM_CH; i++) if ($urandom_range(0, 39) == 0) req[i] = 1'b1;
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      done  = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    req = '0; done = 1'b0; reset = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
